// File: rtl/hall_decoder.sv
// Hall-sensor receiver: synchronises, glitch-filters and sequence-checks the three
// hall lines into a step index, direction and step event, and times step-to-step periods.
module hall_decoder #(
    parameter int unsigned K_FILTER_LEN   = 4,
    parameter int unsigned K_PERIOD_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [2:0]                i_hall,
    input  logic                      i_hall_polarity_rev,
    input  logic                      i_clear_error,
    output logic [2:0]                o_step,
    output logic                      o_step_valid,
    output logic                      o_step_event,
    output logic                      o_direction,
    output logic                      o_hall_error,
    output logic [K_PERIOD_WIDTH-1:0] o_period,
    output logic                      o_period_valid,
    output logic                      o_stalled
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(K_FILTER_LEN);
    localparam logic [K_PERIOD_WIDTH-1:0] PER_MAX = '1;
    localparam logic [K_PERIOD_WIDTH-1:0] PER_ONE = K_PERIOD_WIDTH'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]                cand_q, cand_d, acc_q, acc_d;
    logic [CNT_W-1:0]          stab_q, stab_d;
    logic [2:0]                step_q, step_d;
    logic                      step_valid_q, step_valid_d;
    logic                      step_event_q, step_event_d;
    logic                      direction_q, direction_d;
    logic                      hall_error_q, hall_error_d;
    logic [K_PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [K_PERIOD_WIDTH-1:0] period_q, period_d;
    logic                      period_valid_q, period_valid_d;
    logic                      stalled_q, stalled_d;
    logic                      have_evt_q, have_evt_d;

    logic       accept, code_valid, evt, evt_dir, err_set;
    logic [2:0] code_step;

    // {valid, step} for a hall code; 000 and 111 are illegal
    function automatic logic [3:0] hall_map(input logic [2:0] h);
        case (h)
            3'b001:  return {1'b1, 3'd0};
            3'b011:  return {1'b1, 3'd1};
            3'b010:  return {1'b1, 3'd2};
            3'b110:  return {1'b1, 3'd3};
            3'b100:  return {1'b1, 3'd4};
            3'b101:  return {1'b1, 3'd5};
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] step_inc(input logic [2:0] s);
        return (s == 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    function automatic logic [2:0] step_dec(input logic [2:0] s);
        return (s == 3'd0) ? 3'd5 : s - 3'd1;
    endfunction

    always_comb begin
        sync1_d        = i_hall;
        sync2_d        = sync1_q;
        cand_d         = sync2_q;
        state_d        = state_q;
        step_d         = step_q;
        step_valid_d   = step_valid_q;
        step_event_d   = 1'b0;
        direction_d    = direction_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        have_evt_d     = have_evt_q;
        evt            = 1'b0;
        evt_dir        = 1'b0;
        err_set        = 1'b0;
        per_cnt_d      = (per_cnt_q == PER_MAX) ? PER_MAX : per_cnt_q + PER_ONE;

        // stability filter: a code must sit unchanged for K_FILTER_LEN samples
        if (sync2_q != cand_q) begin
            stab_d = CNT_W'(1);
        end else if (stab_q >= FILT_MAX) begin
            stab_d = FILT_MAX;
        end else begin
            stab_d = stab_q + CNT_W'(1);
        end
        accept = (stab_d == FILT_MAX) && (cand_d != acc_q);
        acc_d  = accept ? cand_d : acc_q;
        {code_valid, code_step} = hall_map(cand_d);

        if (accept) begin
            if (state_q == ST_IDLE) begin
                if (code_valid) begin
                    step_d       = code_step;
                    step_valid_d = 1'b1;
                    state_d      = ST_LOCKED;
                    per_cnt_d    = PER_ONE;
                    have_evt_d   = 1'b0;
                end else begin
                    err_set = 1'b1;
                end
            end else begin
                if (!code_valid) begin
                    err_set        = 1'b1;
                    step_valid_d   = 1'b0;
                    period_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end else if (code_step == step_inc(step_q)) begin
                    evt     = 1'b1;
                    evt_dir = i_hall_polarity_rev;
                end else if (code_step == step_dec(step_q)) begin
                    evt     = 1'b1;
                    evt_dir = ~i_hall_polarity_rev;
                end else begin
                    err_set        = 1'b1;
                    step_d         = code_step;
                    period_valid_d = 1'b0;
                    have_evt_d     = 1'b0;
                end
            end
        end

        // a period is trusted only between two same-direction, unsaturated events
        if (evt) begin
            step_d         = code_step;
            step_event_d   = 1'b1;
            direction_d    = evt_dir;
            period_d       = per_cnt_q;
            per_cnt_d      = PER_ONE;
            period_valid_d = have_evt_q && (evt_dir == direction_q) && (per_cnt_q != PER_MAX);
            have_evt_d     = 1'b1;
        end

        stalled_d = (state_d == ST_LOCKED) && (per_cnt_d == PER_MAX);
        if (stalled_d) begin
            period_valid_d = 1'b0;
        end

        hall_error_d = hall_error_q;
        if (i_clear_error) begin
            hall_error_d = 1'b0;
        end
        if (err_set) begin
            hall_error_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            sync1_q        <= '0;
            sync2_q        <= '0;
            cand_q         <= '0;
            acc_q          <= '0;
            stab_q         <= '0;
            step_q         <= '0;
            step_valid_q   <= 1'b0;
            step_event_q   <= 1'b0;
            direction_q    <= 1'b0;
            hall_error_q   <= 1'b0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            have_evt_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            cand_q         <= cand_d;
            acc_q          <= acc_d;
            stab_q         <= stab_d;
            step_q         <= step_d;
            step_valid_q   <= step_valid_d;
            step_event_q   <= step_event_d;
            direction_q    <= direction_d;
            hall_error_q   <= hall_error_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            have_evt_q     <= have_evt_d;
        end
    end

    assign o_step         = step_q;
    assign o_step_valid   = step_valid_q;
    assign o_step_event   = step_event_q;
    assign o_direction    = direction_q;
    assign o_hall_error   = hall_error_q;
    assign o_period       = period_q;
    assign o_period_valid = period_valid_q;
    assign o_stalled      = stalled_q;

endmodule
